// File: rtl/fetch_buffer_if.sv
// Fetch-to-decode handshake bundle for the fetch buffer.
// The slave side is the buffer itself; the master side is the fetch/decode pair
// (or a testbench standing in for them).
interface fetch_buffer_if #(
    parameter int DEPTH    = 8,
    parameter int WIDTH_PC = 32
);
    // Fetch side: instruction push and pipeline redirect.
    logic                       i_flush;
    logic                       i_wr_en;
    logic [31:0]                i_instr;
    logic [WIDTH_PC-1:0]        i_pc;
    logic                       o_ready;

    // Decode side: head entry presentation and consumption.
    logic                       i_rd_en;
    logic [31:0]                o_instr;
    logic [WIDTH_PC-1:0]        o_pc;
    logic                       o_imask;
    logic [$clog2(DEPTH):0]     o_count;

    modport slave (
        input  i_flush,
        input  i_wr_en,
        input  i_instr,
        input  i_pc,
        input  i_rd_en,
        output o_ready,
        output o_instr,
        output o_pc,
        output o_imask,
        output o_count
    );

    modport master (
        output i_flush,
        output i_wr_en,
        output i_instr,
        output i_pc,
        output i_rd_en,
        input  o_ready,
        input  o_instr,
        input  o_pc,
        input  o_imask,
        input  o_count
    );
endinterface

// File: rtl/fetch_buffer.sv
// Instruction fetch buffer: a first-word-fall-through circular FIFO holding
// {instruction, PC} pairs between fetch and decode. The head entry is shown
// combinationally; an empty buffer presents a NOP at PC 0 with the mask low.
// DEPTH must be a power of two between 2 and 64 so the pointers wrap naturally.
module fetch_buffer #(
    parameter int DEPTH    = 8,
    parameter int WIDTH_PC = 32
) (
    input  logic          i_clk,
    input  logic          i_rst,
    fetch_buffer_if.slave bus
);
    localparam int          PTR_W = $clog2(DEPTH);
    localparam int          CNT_W = PTR_W + 1;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    // Storage: separate arrays for instruction words and their PCs.
    logic [31:0]         instr_mem [DEPTH];
    logic [WIDTH_PC-1:0] pc_mem    [DEPTH];

    // Control state: only these define which storage entries are valid.
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    // Decoded per-cycle actions.
    logic ready;
    logic not_empty;
    logic push;
    logic pop;

    // Space and occupancy come from the registered count only, so a pop in the
    // same cycle never opens room for a push into a full buffer.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        ready     = 1'b0;
        not_empty = 1'b0;
        push      = 1'b0;
        pop       = 1'b0;

        ready     = (count < CNT_W'(DEPTH));
        not_empty = (count != '0);
        push      = bus.i_wr_en && ready     && !bus.i_flush;
        pop       = bus.i_rd_en && not_empty && !bus.i_flush;
    end

    // Pointer and count update; flush wins over any same-cycle push or pop.
    always_ff @(posedge i_clk or posedge i_rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the values from before this edge.
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (bus.i_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage write on an accepted push.
    always_ff @(posedge i_clk) begin
        // NOTE: the arrays have no reset; validity is carried entirely by
        // count and the pointers, so stale contents are never observed.
        if (push) begin
            instr_mem[wr_ptr] <= bus.i_instr;
            pc_mem[wr_ptr]    <= bus.i_pc;
        end
    end

    // Head presentation: straight from storage, NOP at PC 0 when empty.
    always_comb begin
        bus.o_instr = NOP;
        bus.o_pc    = '0;
        if (not_empty) begin
            bus.o_instr = instr_mem[rd_ptr];
            bus.o_pc    = pc_mem[rd_ptr];
        end
    end

    assign bus.o_ready = ready;
    assign bus.o_imask = not_empty;
    assign bus.o_count = count;

endmodule

// File: tb/tb_fetch_buffer.sv
// Self-checking bench for fetch_buffer: a queue-based model checked every
// cycle, plus literal expectations at the key scenario points.
module tb_fetch_buffer;
    localparam int          DEPTH    = 8;
    localparam int          WIDTH_PC = 32;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic i_clk = 1'b0;
    logic i_rst = 1'b1;

    fetch_buffer_if #(.DEPTH(DEPTH), .WIDTH_PC(WIDTH_PC)) bus ();

    fetch_buffer #(.DEPTH(DEPTH), .WIDTH_PC(WIDTH_PC)) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus.slave)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an ordered queue of entries.
    typedef struct {
        logic [31:0]         instr;
        logic [WIDTH_PC-1:0] pc;
    } entry_t;

    entry_t model_q[$];

    always @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            model_q.delete();
        end else if (bus.i_flush) begin
            model_q.delete();
        end else begin
            automatic bit was_full  = (model_q.size() >= DEPTH);
            automatic bit was_empty = (model_q.size() == 0);
            automatic entry_t e;
            e.instr = bus.i_instr;
            e.pc    = bus.i_pc;
            if (bus.i_rd_en && !was_empty) void'(model_q.pop_front());
            if (bus.i_wr_en && !was_full)  model_q.push_back(e);
        end
    end

    // Per-cycle comparison on the falling edge, away from the active edge.
    always @(negedge i_clk) begin
        if (!i_rst) begin
            automatic int sz = model_q.size();
            check("cyc_count", 64'(bus.o_count), 64'(sz));
            check("cyc_imask", 64'(bus.o_imask), 64'(sz != 0));
            check("cyc_ready", 64'(bus.o_ready), 64'(sz < DEPTH));
            check("cyc_instr", 64'(bus.o_instr), (sz != 0) ? 64'(model_q[0].instr) : 64'(NOP));
            check("cyc_pc",    64'(bus.o_pc),    (sz != 0) ? 64'(model_q[0].pc)    : 64'd0);
        end
    end

    task automatic drive(input logic wr, input logic [31:0] instr, input logic [31:0] pc,
                         input logic rd, input logic flush);
        bus.i_wr_en = wr;
        bus.i_instr = instr;
        bus.i_pc    = pc;
        bus.i_rd_en = rd;
        bus.i_flush = flush;
    endtask

    // Apply inputs for one clock, then settle just after the edge.
    task automatic step(input logic wr, input logic [31:0] instr, input logic [31:0] pc,
                        input logic rd, input logic flush);
        drive(wr, instr, pc, rd, flush);
        @(posedge i_clk);
        #1;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic check_empty(input string tag);
        check({tag, "_imask"}, 64'(bus.o_imask), 64'd0);
        check({tag, "_count"}, 64'(bus.o_count), 64'd0);
        check({tag, "_ready"}, 64'(bus.o_ready), 64'd1);
        check({tag, "_instr"}, 64'(bus.o_instr), 64'(NOP));
        check({tag, "_pc"},    64'(bus.o_pc),    64'd0);
    endtask

    initial begin
        int k;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

        // Reset state.
        repeat (2) @(posedge i_clk);
        #1;
        check_empty("reset");
        i_rst = 1'b0;

        // Single push becomes visible one cycle later.
        step(1'b1, 32'h0050_0093, 32'h100, 1'b0, 1'b0);
        check("first_imask", 64'(bus.o_imask), 64'd1);
        check("first_instr", 64'(bus.o_instr), 64'h0050_0093);
        check("first_pc",    64'(bus.o_pc),    64'h100);
        check("first_count", 64'(bus.o_count), 64'd1);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        check_empty("first_pop");

        // Pop on empty is ignored.
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        check_empty("underflow");

        // Fill to DEPTH, drop an extra push, drain in order.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 32'h1000 + i, 32'h200 + 4 * i, 1'b0, 1'b0);
        check("full_count", 64'(bus.o_count), 64'd8);
        check("full_ready", 64'(bus.o_ready), 64'd0);
        step(1'b1, 32'hDEAD_BEEF, 32'hFFC, 1'b0, 1'b0);
        check("drop_count", 64'(bus.o_count), 64'd8);
        for (int i = 0; i < DEPTH; i++) begin
            check("drain_instr", 64'(bus.o_instr), 64'(32'h1000 + i));
            check("drain_pc",    64'(bus.o_pc),    64'(32'h200 + 4 * i));
            step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        end
        check_empty("drained");

        // Full with push and pop together: only the pop happens.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 32'h3000 + i, 32'h400 + 4 * i, 1'b0, 1'b0);
        step(1'b1, 32'hBAD0_0001, 32'h7F0, 1'b1, 1'b0);
        check("fullpp_count", 64'(bus.o_count), 64'd7);
        check("fullpp_ready", 64'(bus.o_ready), 64'd1);
        check("fullpp_instr", 64'(bus.o_instr), 64'h3001);

        // Down to three, then push+pop+flush together.
        for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        check("pre_flush_count", 64'(bus.o_count), 64'd3);
        step(1'b1, 32'h5555_0000, 32'h880, 1'b1, 1'b1);
        check_empty("flush");
        check("flush_wr_ptr", 64'(dut.wr_ptr), 64'd0);
        check("flush_rd_ptr", 64'(dut.rd_ptr), 64'd0);

        // Steady state at four with wrap-around.
        for (int i = 0; i < 4; i++) step(1'b1, 32'h2000 + i, 32'h600 + 4 * i, 1'b0, 1'b0);
        k = 0;
        for (int i = 0; i < 20; i++) begin
            check("wrap_instr", 64'(bus.o_instr), 64'(32'h2000 + k));
            check("wrap_pc",    64'(bus.o_pc),    64'(32'h600 + 4 * k));
            step(1'b1, 32'h2000 + 4 + i, 32'h600 + 4 * (4 + i), 1'b1, 1'b0);
            k++;
            check("wrap_count", 64'(bus.o_count), 64'd4);
        end
        check("wrap_head", 64'(bus.o_instr), 64'(32'h2000 + 20));

        // Asynchronous reset mid-cycle at count five, with a push in flight.
        step(1'b1, 32'h2018, 32'h660, 1'b0, 1'b0);
        check("pre_rst_count", 64'(bus.o_count), 64'd5);
        drive(1'b1, 32'h7777_7777, 32'h990, 1'b0, 1'b0);
        #2;
        i_rst = 1'b1;
        #1;
        check_empty("async_rst");
        @(posedge i_clk);
        #1;
        check_empty("rst_hold");
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        i_rst = 1'b0;
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        check_empty("post_rst");

        // One more push after reset to show the pointers restarted cleanly.
        step(1'b1, 32'h0010_0113, 32'h104, 1'b0, 1'b0);
        check("post_rst_instr", 64'(bus.o_instr), 64'h0010_0113);
        check("post_rst_pc",    64'(bus.o_pc),    64'h104);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Safety net so the run can never hang.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/fetch_buffer.md
FETCH_BUFFER -- requirements
Module: fetch_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 8, buffer entries; power of two, range 2 to 64.
REQ-002 SHALL have parameter WIDTH_PC, default 32, program-counter width.
REQ-003 SHALL have port i_clk, input, 1, sole clock; all state updates on its rising edge.
REQ-004 SHALL have port i_rst, input, 1, reset; asynchronous, active-high.
REQ-005 SHALL have port i_flush, input, 1, discard all buffered entries (redirect or mispredict).
REQ-006 SHALL have port i_wr_en, input, 1, fetch presents a valid instruction this cycle.
REQ-007 SHALL have port i_instr, input, 32, fetched instruction word.
REQ-008 SHALL have port i_pc, input, WIDTH_PC, PC of i_instr.
REQ-009 SHALL have port o_ready, input-side, output, 1, high when a push is accepted this cycle.
REQ-010 SHALL have port i_rd_en, input, 1, decode consumes the head entry this cycle.
REQ-011 SHALL have port o_instr, output, 32, head instruction, which drives the decode instruction input.
REQ-012 SHALL have port o_pc, output, WIDTH_PC, PC of the head instruction.
REQ-013 SHALL have port o_imask, output, 1, head valid, which drives the decode instruction-mask input.
REQ-014 SHALL have port o_count, output, clog2(DEPTH)+1, number of valid entries.

Function
REQ-015 SHALL implement a circular FIFO with a write pointer, a read pointer (each clog2(DEPTH) bits, wrapping DEPTH-1 to 0) and a count register.
REQ-016 SHALL set o_ready = (count < DEPTH), computed from registered count only; a pop in the same cycle SHALL NOT enable a push when full.
REQ-017 SHALL accept a push when i_wr_en && o_ready && !i_flush: store {i_instr, i_pc} at wr_ptr and increment wr_ptr.
REQ-018 SHALL perform a pop when i_rd_en && o_imask && !i_flush: increment rd_ptr.
REQ-019 SHALL ignore i_rd_en when empty; count SHALL NOT underflow.
REQ-020 SHALL handle a simultaneous push and pop so that count is unchanged and both pointers advance.
REQ-021 SHALL be first-word-fall-through: o_instr/o_pc = entry at rd_ptr combinationally from storage; zero latency from a registered entry to the output.
REQ-022 SHALL make a pushed entry visible at the outputs in the cycle after the push edge (1-cycle write-to-read latency).
REQ-023 SHALL set o_imask = (count != 0).
REQ-024 SHALL drive o_instr = 32'h00000013 (NOP) and o_pc = 0 when empty.
REQ-025 SHALL, on i_flush, set count, wr_ptr and rd_ptr to 0 at the next edge; flush SHALL take priority over a same-cycle push and pop.
REQ-026 SHALL treat storage contents as don't-care after a flush; only count/pointers define validity.
REQ-027 SHALL make o_count equal the registered count.

Reset
REQ-028 SHALL, while i_rst is high, asynchronously force count=0, wr_ptr=0, rd_ptr=0, giving o_imask=0, o_ready=1, o_count=0, o_instr=32'h00000013, o_pc=0.
REQ-029 SHALL NOT require storage array reset.
REQ-030 SHALL discard all entries and any in-flight push when reset is asserted mid-operation.

Verification
REQ-031 SHALL cover reset then push 0x00500093 @pc 0x100 -> next cycle o_imask=1, o_instr=0x00500093, o_pc=0x100, o_count=1.
REQ-032 SHALL cover pushing DEPTH (8) entries with no pops -> o_count=8, o_ready=0; a 9th i_wr_en is dropped; popping 8 returns entries in order, then o_imask=0 and o_instr=0x00000013.
REQ-033 SHALL cover, when full, i_wr_en and i_rd_en both high -> pop only, o_count 8->7, o_ready=1 next cycle.
REQ-034 SHALL cover, at count=3, simultaneous push, pop and i_flush -> next cycle o_count=0, o_imask=0, pointers 0.
REQ-035 SHALL cover 20 push/pop pairs at count=4 (wrap-around) -> o_count stays 4 and the output sequence matches input order.
REQ-036 SHALL cover i_rst asserted asynchronously mid-cycle at count=5 -> outputs at reset values immediately, before the next i_clk edge.
